// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of words feeding a frame serializer with
// configurable data width, parity mode and stop-bit count.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          en,
    output logic                          rdy,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count_q;
    logic                 wr_en, pop, ovf_q;
    logic [DATA_BITS-1:0] head;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 dout_q, dout_d;
    logic                 tick, load;

    assign rdy        = (count_q != (AW+1)'(FIFO_DEPTH));
    assign wr_en      = en && rdy;
    assign head       = mem[rd_ptr];
    assign tick       = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign dout       = dout_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        dout_d  = dout_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                dout_d = 1'b1;
                if (count_q != '0) load = 1'b1;
            end
            S_START: if (tick) begin
                dout_d  = sh_q[0];
                sh_d    = sh_q >> 1;
                idx_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: if (tick) begin
                if (idx_q == IW'(DATA_BITS - 1)) begin
                    idx_d = '0;
                    if (PARITY != 0) begin
                        state_d = S_PAR;
                        dout_d  = par_q;
                    end else begin
                        state_d = S_STOP;
                        dout_d  = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q + IW'(1);
                    dout_d = sh_q[0];
                    sh_d   = sh_q >> 1;
                end
            end
            S_PAR: if (tick) begin
                state_d = S_STOP;
                dout_d  = 1'b1;
                idx_d   = '0;
            end
            S_STOP: if (tick) begin
                // idx reused to count stop-bit periods
                if (idx_q == IW'(STOP_BITS - 1)) begin
                    if (count_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        dout_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // New frame: start bit goes out on the same edge the head is popped
        if (load) begin
            pop     = 1'b1;
            sh_d    = head;
            par_d   = (PARITY == 1) ? ~(^head) : ^head;
            dout_d  = 1'b0;
            state_d = S_START;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            ovf_q   <= en && !rdy;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr] <= data_in;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame configurations share one stimulus stream,
// each checked every cycle against a queue-and-frame-image model.
module tb_uart_tx_fifo;
    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [8:0] din = '0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         trk = 1'b0;
    int         max_c = 0;

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int CPB = (g == 2) ? 3 : 4;
        localparam int DB  = (g == 2) ? 7 : 8;
        localparam int PAR = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int STP = (g == 2) ? 2 : 1;
        localparam int DEP = (g == 2) ? 8 : 4;

        logic                    rdy_w, dout_w, busy_w, ovf_w;
        logic [$clog2(DEP):0]    cnt_w;

        uart_tx_fifo #(
            .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR),
            .STOP_BITS(STP), .FIFO_DEPTH(DEP)
        ) u_dut (
            .clk(tb_clk), .rst(rst), .data_in(din[DB-1:0]), .en(en),
            .rdy(rdy_w), .dout(dout_w), .busy(busy_w),
            .fifo_count(cnt_w), .overflow(ovf_w)
        );

        // Model: word queue plus the full bit image of the frame on the line
        int        q[$];
        bit [15:0] fr = '0;
        int        pos = 0;
        int        len = 0;
        bit        act = 1'b0;
        bit        m_ovf = 1'b0;

        always @(posedge tb_clk) begin : mdl
            int sz, w, nb;
            bit wr, par;
            sz = q.size();
            if (rst) begin
                q.delete();
                act   = 1'b0;
                m_ovf = 1'b0;
            end else begin
                wr    = en && (sz < DEP);
                m_ovf = en && (sz >= DEP);
                if (act && pos < len - 1) begin
                    pos++;
                end else if (sz > 0) begin
                    w   = q.pop_front();
                    fr  = '0;
                    par = 1'b0;
                    for (int i = 0; i < DB; i++) begin
                        fr[1+i] = w[i];
                        par ^= w[i];
                    end
                    nb = 1 + DB;
                    if (PAR != 0) begin
                        fr[nb] = (PAR == 1) ? ~par : par;
                        nb++;
                    end
                    for (int s = 0; s < STP; s++) begin
                        fr[nb] = 1'b1;
                        nb++;
                    end
                    len = nb * CPB;
                    pos = 0;
                    act = 1'b1;
                end else begin
                    act = 1'b0;
                end
                if (wr) q.push_back(int'(din) & ((1 << DB) - 1));
            end
        end

        always @(negedge tb_clk) begin
            chk($sformatf("cfg%0d dout", g), dout_w, act ? fr[pos / CPB] : 1'b1);
            chk($sformatf("cfg%0d busy", g), busy_w, act || (q.size() > 0));
            chk($sformatf("cfg%0d fifo_count", g), cnt_w, q.size());
            chk($sformatf("cfg%0d rdy", g), rdy_w, q.size() < DEP);
            chk($sformatf("cfg%0d overflow", g), ovf_w, m_ovf);
        end
    end

    always @(negedge tb_clk) if (trk && int'(g_cfg[0].cnt_w) > max_c) max_c = int'(g_cfg[0].cnt_w);

    task automatic wait_idle();
        int t = 0;
        while ((g_cfg[0].busy_w || g_cfg[1].busy_w || g_cfg[2].busy_w) && t < 3000) begin
            @(negedge tb_clk);
            t++;
        end
        chk("idle wait timeout", t < 3000, 1'b1);
    endtask

    initial begin
        logic [39:0] got, expv;
        logic [9:0]  slots;
        int          n_ovf, ovf_k, w;

        // reset with en high: nothing may be stored
        en  = 1'b1;
        din = 9'h1AB;
        repeat (3) @(negedge tb_clk);
        chk("reset dout", g_cfg[0].dout_w, 1'b1);
        chk("reset busy", g_cfg[0].busy_w, 1'b0);
        chk("reset count", g_cfg[0].cnt_w, 0);
        chk("reset rdy", g_cfg[0].rdy_w, 1'b1);
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge tb_clk);

        // 8N1 frame of 0x55 on cfg0
        slots = 10'b1010101010;
        din = 9'h055; en = 1'b1;
        @(negedge tb_clk);
        en = 1'b0;
        chk("8n1 busy at write", g_cfg[0].busy_w, 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge tb_clk);
            got[k]  = g_cfg[0].dout_w;
            expv[k] = slots[k / 4];
            if (k == 39) chk("8n1 busy last cycle", g_cfg[0].busy_w, 1'b1);
        end
        chk("8n1 frame bits", got, expv);
        @(negedge tb_clk);
        chk("8n1 busy after frame", g_cfg[0].busy_w, 1'b0);
        wait_idle();

        // parity slots and frame lengths with 0xA5
        din = 9'h0A5; en = 1'b1;
        @(negedge tb_clk);
        en = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(negedge tb_clk);
            if (k == 38) chk("even parity bit", g_cfg[1].dout_w, 1'b0);
            if (k == 25) chk("odd parity bit 7b", g_cfg[2].dout_w, 1'b0);
            if (k == 32) chk("7o2 busy last cycle", g_cfg[2].busy_w, 1'b1);
            if (k == 33) chk("7o2 busy after frame", g_cfg[2].busy_w, 1'b0);
            if (k == 43) chk("8e1 busy last cycle", g_cfg[1].busy_w, 1'b1);
            if (k == 44) chk("8e1 busy after frame", g_cfg[1].busy_w, 1'b0);
        end
        wait_idle();

        // six-cycle burst into a depth-4 FIFO
        n_ovf = 0; ovf_k = -1;
        for (int k = 0; k < 7; k++) begin
            en  = (k < 6);
            din = 9'(k + 1);
            @(negedge tb_clk);
            if (g_cfg[0].ovf_w) begin
                n_ovf++;
                ovf_k = k;
            end
            if (k == 5) chk("burst count full", g_cfg[0].cnt_w, 4);
        end
        en = 1'b0;
        chk("burst overflow pulses", n_ovf, 1);
        chk("burst overflow cycle", ovf_k, 5);
        wait_idle();

        // reset during data bit 3 of 0xFF with two words queued
        din = 9'h0FF; en = 1'b1;
        @(negedge tb_clk);
        din = 9'h011;
        @(negedge tb_clk);
        din = 9'h022;
        @(negedge tb_clk);
        en = 1'b0;
        repeat (15) @(negedge tb_clk);
        chk("pre-reset data bit 3", g_cfg[0].dout_w, 1'b1);
        chk("pre-reset count", g_cfg[0].cnt_w, 2);
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        chk("abort dout", g_cfg[0].dout_w, 1'b1);
        chk("abort count", g_cfg[0].cnt_w, 0);
        chk("abort busy", g_cfg[0].busy_w, 1'b0);
        chk("abort busy 7o2", g_cfg[2].busy_w, 1'b0);
        repeat (60) @(negedge tb_clk);
        chk("post-abort quiet", g_cfg[0].busy_w, 1'b0);

        // wrap-around: 0x10..0x19 in bursts of three
        trk = 1'b1; max_c = 0; w = 0;
        while (w < 10) begin
            for (int k = 0; k < 3 && w < 10; k++) begin
                din = 9'(8'h10 + w); en = 1'b1;
                @(negedge tb_clk);
                w++;
            end
            en = 1'b0;
            wait_idle();
        end
        trk = 1'b0;
        chk("wrap max count <= 3", max_c <= 3, 1'b1);

        // random traffic with occasional reset
        for (int c = 0; c < 1500; c++) begin
            din = 9'($urandom);
            en  = ($urandom_range(0, 9) < 4);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge tb_clk);
        end
        en = 1'b0; rst = 1'b0;
        wait_idle();
        @(negedge tb_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the fixed-format 8N1 UART transmitter used by the glitcher host link and testbenches.
- Adds a configurable frame: data width, parity mode and stop-bit count.
- Adds a write FIFO so a host or command engine can queue a burst of bytes without waiting on `rdy` per byte.
- Sits between the command/response logic and the `ftdi_rx` output pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- data_in  in  DATA_BITS  word to enqueue
- en  in  1  write strobe; word accepted when en && rdy at a rising edge
- rdy  out  1  FIFO not full (combinational from registered count)
- dout  out  1  serial line, idle high, registered
- busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  one-cycle pulse when en is high and rdy is low (word dropped)

Behaviour:
- Reset values (rst sampled high at an edge):
  - FIFO flushed, fifo_count=0, rdy=1.
  - dout=1, busy=0, overflow=0.
  - FSM returns to IDLE and the bit counter clears.
  - A frame in progress is aborted: dout returns high at that edge with no stop-bit completion.
- FIFO:
  - Write on en && rdy.
  - Pop only by the FSM, when loading a new frame.
  - Simultaneous write and pop: count unchanged, both take effect.
  - When full, rdy=0, so a write is dropped even if a pop happens that edge.
  - A dropped write pulses overflow for exactly one cycle and does not corrupt stored data.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: dout=1. If the FIFO is non-empty, pop the head into the shift register, dout<=0, go to START. A word written at edge E into an empty FIFO while idle pops at edge E+1, so dout falls at E+1.
  - START: hold dout=0 for CLKS_PER_BIT cycles, then drive data bit 0.
  - DATA: shift out DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles. Then go to PARITY if PARITY≠0, else STOP.
  - PARITY: parity bit held CLKS_PER_BIT cycles.
    - Even: parity = XOR of the data bits.
    - Odd: parity = inverted XOR of the data bits.
    - Parity is computed at load time from the popped word.
  - STOP: dout=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end of the period:
    - If the FIFO is non-empty, pop and drive the next start bit on the same edge, with zero idle gap between frames.
    - Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles exactly.
- Bit counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT−1, with the bit boundary at terminal count.
- Data-bit index counter wraps to 0 on each new frame.
- en is ignored during reset; words presented during reset are not stored.
- busy falls on the edge where the FSM enters IDLE with the FIFO empty.

Test Plan:
- Default 8N1, CLKS_PER_BIT=4, PARITY=0. Write 0x55 while idle at edge E → dout=0 for 4 cycles from E+1, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles. Total frame 40 cycles; busy high E..E+40, then low.
- PARITY=2 (even) with 0xA5, then PARITY=1 (odd) with 0xA5 → parity bit slot is 0 (even) and 1 (odd). Frame length 44 cycles with CLKS_PER_BIT=4.
- FIFO_DEPTH=4, en held high for 6 consecutive cycles (bytes 0x01..0x06) while idle:
  - First word pops one edge after its write, so 5 are accepted and 0x06 is dropped.
  - overflow pulses once on the 6th cycle.
  - Serial output is 0x01..0x05 back-to-back with no idle gap between stop and start bits.
- STOP_BITS=2, DATA_BITS=7, bytes 0x7F and 0x00 queued → each frame is 10×CLKS_PER_BIT cycles with dout high for 2 bit periods between frames. The 8th input bit never appears on the line.
- Reset mid-frame: assert rst during data bit 3 of 0xFF with two more words queued → dout=1, fifo_count=0, busy=0 at the next edge. Nothing is transmitted after rst deasserts until a new write.
- Wrap-around: FIFO_DEPTH=4, write and drain 10 words (0x10..0x19) in bursts of 3 → transmitted order matches written order exactly, and fifo_count never exceeds 3.
